// File: rtl/conv_pad_sched_pkg.sv
// Shared geometry constants, state encoding and layer-size lookup for conv_pad_sched.
package conv_pad_sched_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ROW_W_DEF  = 9;

    localparam logic [8:0] W_416 = 9'd416;
    localparam logic [8:0] W_208 = 9'd208;
    localparam logic [8:0] W_104 = 9'd104;
    localparam logic [8:0] W_52  = 9'd52;
    localparam logic [8:0] W_26  = 9'd26;
    localparam logic [8:0] W_13  = 9'd13;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PAD_TOP = 3'd1,
        BODY    = 3'd2,
        PAD_BOT = 3'd3,
        FIN     = 3'd4
    } state_e;

    // Codes 6 and 7 have no map size of their own and alias the largest map.
    function automatic logic [2:0] norm_sel(input logic [2:0] sel);
        logic [2:0] ns;
        case (sel)
            3'd6, 3'd7: ns = 3'd0;
            default:    ns = sel;
        endcase
        return ns;
    endfunction

    function automatic logic [8:0] pad_size(input logic [2:0] sel);
        logic [8:0] w;
        case (norm_sel(sel))
            3'd1:    w = W_208;
            3'd2:    w = W_104;
            3'd3:    w = W_52;
            3'd4:    w = W_26;
            3'd5:    w = W_13;
            default: w = W_416;
        endcase
        return w + 9'd2;
    endfunction

endpackage

// File: rtl/conv_pad_sched_cnt.sv
// pad_rowcol_cnt: raster row/column counter over a P x P padded frame.
module pad_rowcol_cnt #(
    parameter int ROW_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [ROW_W-1:0] p_i,
    output logic [ROW_W-1:0] row_o,
    output logic [ROW_W-1:0] col_o,
    output logic             col_last_o,
    output logic             frame_last_o
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] col_q, col_d;
    logic             col_last_s;

    assign col_last_s = (col_q == (p_i - ROW_W'(1)));

    // Next position: column wraps at P-1 and carries into the row.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = {ROW_W{1'b0}};
            col_d = {ROW_W{1'b0}};
        end else if (en_i) begin
            if (col_last_s) begin
                col_d = {ROW_W{1'b0}};
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + ROW_W'(1);
            end
        end else begin
            row_d = row_q;
            col_d = col_q;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= {ROW_W{1'b0}};
            col_q <= {ROW_W{1'b0}};
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o        = row_q;
    assign col_o        = col_q;
    assign col_last_o   = col_last_s;
    assign frame_last_o = col_last_s && (row_q == (p_i - ROW_W'(1)));

endmodule

// File: rtl/conv_pad_sched.sv
// Zero-border frame sequencer feeding the 3-line conv buffer; optional statistics
// counters are built when CONV_PAD_STAT_EN is defined.
module conv_pad_sched
    import conv_pad_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ROW_W  = ROW_W_DEF
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              start,
    input  logic [2:0]        layer_sel,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [DATA_W-1:0] data_in,
    output logic              data_in_vld,
    output logic [2:0]        feature_col_select,
    output logic [6:0]        padding_row_cnt,
    output logic              busy,
    output logic              done,
    output logic              err_underflow
`ifdef CONV_PAD_STAT_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       underflow_cnt
`endif
);

    state_e            state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;
    logic [6:0]        rcnt_q, rcnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [ROW_W-1:0]  p_s, row_s, col_s;
    logic              col_last_s, frame_last_s, body_last_s;
    logic              start_acc_s, emit_s, in_rdy_s, accept_s, underflow_s;

    assign p_s         = ROW_W'(pad_size(sel_q));
    assign body_last_s = col_last_s && (row_s == (p_s - ROW_W'(2)));
    assign emit_s      = (state_q == PAD_TOP) || (state_q == BODY) || (state_q == PAD_BOT);
    assign in_rdy_s    = (state_q == BODY) && (col_s != {ROW_W{1'b0}}) && !col_last_s;
    assign accept_s    = in_rdy_s && in_vld;
    assign underflow_s = in_rdy_s && !in_vld;

    pad_rowcol_cnt #(.ROW_W(ROW_W)) u_cnt (
        .clk          (sclk),
        .rst          (s_rst),
        .clr_i        (state_q == IDLE),
        .en_i         (emit_s),
        .p_i          (p_s),
        .row_o        (row_s),
        .col_o        (col_s),
        .col_last_o   (col_last_s),
        .frame_last_o (frame_last_s)
    );

    // Frame sequencing; start is only honoured from IDLE.
    always_comb begin
        state_d     = state_q;
        start_acc_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = PAD_TOP;
                    start_acc_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            PAD_TOP: begin
                if (col_last_s) state_d = BODY;
                else            state_d = PAD_TOP;
            end
            BODY: begin
                if (body_last_s) state_d = PAD_BOT;
                else             state_d = BODY;
            end
            PAD_BOT: begin
                if (frame_last_s) state_d = FIN;
                else              state_d = PAD_BOT;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output word path: every emitting cycle produces a word, zero unless accepted.
    always_comb begin
        sel_d  = start_acc_s ? norm_sel(layer_sel) : sel_q;
        data_d = accept_s ? in_data : {DATA_W{1'b0}};
        vld_d  = emit_s;
        if (!emit_s) begin
            rcnt_d = 7'd0;
        end else if (row_s > ROW_W'(127)) begin
            rcnt_d = 7'd127;
        end else begin
            rcnt_d = row_s[6:0];
        end
        busy_d = (state_d == PAD_TOP) || (state_d == BODY) || (state_d == PAD_BOT);
        done_d = (state_d == FIN);
        err_d  = start_acc_s ? 1'b0 : (err_q || underflow_s);
    end

    // State and registered outputs.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            data_q  <= {DATA_W{1'b0}};
            vld_q   <= 1'b0;
            rcnt_q  <= 7'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            rcnt_q  <= rcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_rdy             = in_rdy_s;
    assign data_in            = data_q;
    assign data_in_vld        = vld_q;
    assign feature_col_select = sel_q;
    assign padding_row_cnt    = rcnt_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err_underflow      = err_q;

`ifdef CONV_PAD_STAT_EN
    logic [15:0] fcnt_q, fcnt_d;
    logic [15:0] ucnt_q, ucnt_d;

    // Frame counter wraps; underflow counter saturates and restarts per frame.
    always_comb begin
        fcnt_d = done_d ? (fcnt_q + 16'd1) : fcnt_q;
        if (start_acc_s) begin
            ucnt_d = 16'd0;
        end else if (underflow_s && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end else begin
            ucnt_d = ucnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            fcnt_q <= 16'd0;
            ucnt_q <= 16'd0;
        end else begin
            fcnt_q <= fcnt_d;
            ucnt_q <= ucnt_d;
        end
    end

    assign frame_cnt     = fcnt_q;
    assign underflow_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_conv_pad_sched.sv
// Directed self-checking bench for conv_pad_sched (statistics ports checked when
// CONV_PAD_STAT_EN is defined).
module tb_conv_pad_sched;

    logic        sclk = 1'b0;
    logic        s_rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  layer_sel = 3'd0;
    logic [63:0] in_data = 64'd0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [63:0] data_in;
    logic        data_in_vld;
    logic [2:0]  feature_col_select;
    logic [6:0]  padding_row_cnt;
    logic        busy;
    logic        done;
    logic        err_underflow;
`ifdef CONV_PAD_STAT_EN
    logic [15:0] frame_cnt;
    logic [15:0] underflow_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sclk = ~sclk;

    conv_pad_sched dut (
        .sclk               (sclk),
        .s_rst              (s_rst),
        .start              (start),
        .layer_sel          (layer_sel),
        .in_data            (in_data),
        .in_vld             (in_vld),
        .in_rdy             (in_rdy),
        .data_in            (data_in),
        .data_in_vld        (data_in_vld),
        .feature_col_select (feature_col_select),
        .padding_row_cnt    (padding_row_cnt),
        .busy               (busy),
        .done               (done),
        .err_underflow      (err_underflow)
`ifdef CONV_PAD_STAT_EN
        ,
        .frame_cnt          (frame_cnt),
        .underflow_cnt      (underflow_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit interior(input int k, input int p);
        int r;
        int c;
        r = k / p;
        c = k % p;
        return (r >= 1) && (r <= p - 2) && (c >= 1) && (c <= p - 2);
    endfunction

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_data"}, data_in, 64'd0);
        check_eq({tag, "_vld"}, {63'd0, data_in_vld}, 64'd0);
        check_eq({tag, "_fcs"}, {61'd0, feature_col_select}, 64'd0);
        check_eq({tag, "_rowcnt"}, {57'd0, padding_row_cnt}, 64'd0);
        check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check_eq({tag, "_done"}, {63'd0, done}, 64'd0);
        check_eq({tag, "_err"}, {63'd0, err_underflow}, 64'd0);
        check_eq({tag, "_rdy"}, {63'd0, in_rdy}, 64'd0);
    endtask

    // One frame: words appear one cycle after the cycle that produced them.
    task automatic run_frame(input logic [2:0] sel, input int p, input logic [2:0] exp_fcs,
                             input int bub_at, input int bub_len,
                             input int restart_at, input int abort_at);
        int          total;
        int          k;
        int          r;
        int          acc_obs;
        int          vld_obs;
        logic [63:0] next_val;
        logic [63:0] exp_prev;
        logic [63:0] exp_cur;
        bit          vld_j;
        bit          uf_seen;
        bit          aborted;
        total    = p * p;
        next_val = 64'd1;
        exp_prev = 64'd0;
        uf_seen  = 1'b0;
        aborted  = 1'b0;
        acc_obs  = 0;
        vld_obs  = 0;
        @(posedge sclk);
        #1;
        layer_sel = sel;
        start     = 1'b1;
        in_vld    = 1'b0;
        @(posedge sclk);
        #1;
        for (int j = 0; j <= total + 1; j++) begin
            vld_j   = !((j >= bub_at) && (j < bub_at + bub_len));
            in_vld  = vld_j;
            in_data = next_val;
            start   = (j == restart_at);
            exp_cur = ((j < total) && interior(j, p) && vld_j) ? next_val : 64'd0;
            @(negedge sclk);
            k = j - 1;
            if ((k >= 0) && (k < total)) begin
                r = k / p;
                check_eq("word_data", data_in, exp_prev);
                check_eq("word_vld", {63'd0, data_in_vld}, 64'd1);
                check_eq("word_rowcnt", {57'd0, padding_row_cnt}, (r > 127) ? 64'd127 : 64'(r));
            end else begin
                check_eq("gap_vld", {63'd0, data_in_vld}, 64'd0);
            end
            check_eq("busy", {63'd0, busy}, (j < total) ? 64'd1 : 64'd0);
            check_eq("done", {63'd0, done}, (j == total) ? 64'd1 : 64'd0);
            check_eq("err_underflow", {63'd0, err_underflow}, {63'd0, uf_seen});
            check_eq("in_rdy", {63'd0, in_rdy}, ((j < total) && interior(j, p)) ? 64'd1 : 64'd0);
            check_eq("fcs", {61'd0, feature_col_select}, {61'd0, exp_fcs});
            if (in_rdy && in_vld) acc_obs++;
            if (data_in_vld) vld_obs++;
            if ((j < total) && interior(j, p)) begin
                if (vld_j) next_val = next_val + 64'd1;
                else       uf_seen  = 1'b1;
            end
            exp_prev = exp_cur;
            if (j == abort_at) begin
                aborted = 1'b1;
                break;
            end
            @(posedge sclk);
            #1;
        end
        start  = 1'b0;
        in_vld = 1'b0;
        if (aborted) begin
            s_rst = 1'b1;
            @(posedge sclk);
            #1;
            check_idle_zero("abort");
            repeat (3) begin
                @(negedge sclk);
                check_eq("abort_no_done", {63'd0, done}, 64'd0);
            end
            s_rst = 1'b0;
        end else begin
            check_eq("accepted_words", 64'(acc_obs), 64'((p - 2) * (p - 2) - bub_len));
            check_eq("valid_words", 64'(vld_obs), 64'(total));
        end
    endtask

    initial begin
        s_rst = 1'b1;
        repeat (2) @(posedge sclk);
        #1;
        check_idle_zero("reset");
        @(negedge sclk);
        s_rst = 1'b0;

        // 13x13 map: clean frame, then a 3-cycle bubble in row 4.
        run_frame(3'd5, 15, 3'd5, -10, 0, -1, -1);
        run_frame(3'd5, 15, 3'd5, 66, 3, -1, -1);
        check_eq("err_sticky", {63'd0, err_underflow}, 64'd1);
`ifdef CONV_PAD_STAT_EN
        check_eq("frame_cnt_2", {48'd0, frame_cnt}, 64'd2);
        check_eq("underflow_cnt_3", {48'd0, underflow_cnt}, 64'd3);
`endif
        // Restart pulse mid-frame is ignored; err flag cleared by this start.
        run_frame(3'd5, 15, 3'd5, -10, 0, 50, -1);
`ifdef CONV_PAD_STAT_EN
        check_eq("frame_cnt_3", {48'd0, frame_cnt}, 64'd3);
        check_eq("underflow_cnt_0", {48'd0, underflow_cnt}, 64'd0);
`endif
        // Reset at word 100, then a clean frame with start held in the FIN cycle.
        run_frame(3'd5, 15, 3'd5, -10, 0, -1, 100);
        run_frame(3'd5, 15, 3'd5, -10, 0, 225, -1);
        run_frame(3'd4, 28, 3'd4, 100, 2, -1, -1);
        // Largest map: run into row 128 to see row counter saturation.
        run_frame(3'd0, 418, 3'd0, -10, 0, -1, 128 * 418 + 5);
        run_frame(3'd7, 418, 3'd0, -10, 0, -1, 500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
